// File: rtl/ysyx_22050550_bypass_sb.sv
// rtl/ysyx_22050550_bypass_sb.sv - ID-stage operand bypass, long-op scoreboard and hazard stall unit
module ysyx_22050550_bypass_sb #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int NRP    = 2,
  parameter int NSTAGE = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [NRP-1:0]         id_ren,
  input  logic [NRP*AW-1:0]      id_raddr,
  input  logic                   id_wen,
  input  logic [AW-1:0]          id_waddr,
  input  logic                   id_long,
  output logic [NRP-1:0]         id_fwd_hit,
  output logic [NRP*XLEN-1:0]    id_fwd_data,
  output logic                   id_stall,
  input  logic                   issue_fire,
  input  logic [NSTAGE-1:0]      src_valid,
  input  logic [NSTAGE-1:0]      src_wen,
  input  logic [NSTAGE*AW-1:0]   src_waddr,
  input  logic [NSTAGE-1:0]      src_rdy,
  input  logic [NSTAGE*XLEN-1:0] src_data,
  input  logic                   lg_done,
  input  logic [AW-1:0]          lg_waddr,
  input  logic [XLEN-1:0]        lg_data,
  input  logic                   flush,
  output logic [31:0]            stall_cnt
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0]      busy_q, busy_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;

  logic [NRP-1:0]       hit_raw;
  logic [NRP*XLEN-1:0]  data_raw;
  logic [NRP-1:0]       port_stall;
  logic [AW-1:0]        rd_addr;
  logic                 matched;
  logic                 waw_stall;

  // Per-port forwarding: youngest matching stage wins; a non-ready winner blocks older sources
  always_comb begin
    hit_raw    = '0;
    data_raw   = '0;
    port_stall = '0;
    rd_addr    = '0;
    matched    = 1'b0;
    for (int p = 0; p < NRP; p++) begin
      rd_addr = id_raddr[p*AW +: AW];
      matched = 1'b0;
      if (id_valid && id_ren[p] && (rd_addr != '0)) begin
        for (int s = 0; s < NSTAGE; s++) begin
          if (!matched && src_valid[s] && src_wen[s] && (src_waddr[s*AW +: AW] == rd_addr)) begin
            matched = 1'b1;
            if (src_rdy[s]) begin
              hit_raw[p]                 = 1'b1;
              data_raw[p*XLEN +: XLEN]   = src_data[s*XLEN +: XLEN];
            end else begin
              port_stall[p] = 1'b1;
            end
          end
        end
        if (!matched) begin
          if (lg_done && (lg_waddr == rd_addr)) begin
            hit_raw[p]               = 1'b1;
            data_raw[p*XLEN +: XLEN] = lg_data;
          end else if (busy_q[rd_addr]) begin
            port_stall[p] = 1'b1;
          end
        end
      end
    end
  end

  // A second long op to a still-owed register must wait so results retire in order
  always_comb begin
    waw_stall = id_valid && id_wen && id_long && (id_waddr != '0) && busy_q[id_waddr]
                && !(lg_done && (lg_waddr == id_waddr));
  end

  // Outputs are forced quiet while reset is held; flush cancels any stall
  always_comb begin
    id_stall    = reset && !flush && ((|port_stall) || waw_stall);
    id_fwd_hit  = reset ? hit_raw : '0;
    id_fwd_data = reset ? data_raw : '0;
    stall_cnt   = stall_cnt_q;
  end

  // Scoreboard next state: flush kills everything; a new owner beats a same-cycle writeback
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (lg_done) busy_d[lg_waddr] = 1'b0;
      if (issue_fire && id_wen && id_long && (id_waddr != '0)) busy_d[id_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Saturating stall-cycle counter
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050550_bypass_sb.sv
// tb/tb_ysyx_22050550_bypass_sb.sv - scoreboard bench with random and directed stimulus for the bypass unit
module tb_ysyx_22050550_bypass_sb;

  localparam int XLEN = 64, AW = 5, NRP = 2, NSTAGE = 3, NREG = 32;

  logic                   clock = 0;
  logic                   reset;
  logic                   id_valid;
  logic [NRP-1:0]         id_ren;
  logic [NRP*AW-1:0]      id_raddr;
  logic                   id_wen;
  logic [AW-1:0]          id_waddr;
  logic                   id_long;
  logic [NRP-1:0]         id_fwd_hit;
  logic [NRP*XLEN-1:0]    id_fwd_data;
  logic                   id_stall;
  logic                   issue_fire;
  logic [NSTAGE-1:0]      src_valid, src_wen, src_rdy;
  logic [NSTAGE*AW-1:0]   src_waddr;
  logic [NSTAGE*XLEN-1:0] src_data;
  logic                   lg_done;
  logic [AW-1:0]          lg_waddr;
  logic [XLEN-1:0]        lg_data;
  logic                   flush;
  logic [31:0]            stall_cnt;

  ysyx_22050550_bypass_sb #(.XLEN(XLEN), .AW(AW), .NRP(NRP), .NSTAGE(NSTAGE)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ren(id_ren), .id_raddr(id_raddr),
    .id_wen(id_wen), .id_waddr(id_waddr), .id_long(id_long), .id_fwd_hit(id_fwd_hit),
    .id_fwd_data(id_fwd_data), .id_stall(id_stall), .issue_fire(issue_fire),
    .src_valid(src_valid), .src_wen(src_wen), .src_waddr(src_waddr), .src_rdy(src_rdy),
    .src_data(src_data), .lg_done(lg_done), .lg_waddr(lg_waddr), .lg_data(lg_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NRP-1:0]      hit;
    logic [NRP*XLEN-1:0] data;
    logic                stall;
    logic [31:0]         cnt;
  } exp_t;

  exp_t        exp_q[$];
  bit          mbusy[NREG];
  logic [31:0] mcnt;
  int          checks = 0;
  int          errors = 0;
  bit          drv_done = 0;

  task automatic clear_inputs();
    id_valid = 0; id_ren = '0; id_raddr = '0; id_wen = 0; id_waddr = '0; id_long = 0;
    issue_fire = 0; src_valid = '0; src_wen = '0; src_waddr = '0; src_rdy = '0;
    src_data = '0; lg_done = 0; lg_waddr = '0; lg_data = '0; flush = 0;
  endtask

  task automatic set_src(input int s, input logic [AW-1:0] a, input logic rdy, input logic [XLEN-1:0] d);
    src_valid[s] = 1; src_wen[s] = 1; src_waddr[s*AW +: AW] = a;
    src_rdy[s] = rdy; src_data[s*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    id_valid = 1; id_ren[p] = 1; id_raddr[p*AW +: AW] = a;
  endtask

  // Reference model: expected outputs from the architectural rules and the model scoreboard
  task automatic predict(output exp_t e);
    logic [AW-1:0] a;
    int            w;
    bit            st;
    st = 0;
    e.hit = '0; e.data = '0;
    for (int p = 0; p < NRP; p++) begin
      a = id_raddr[p*AW +: AW];
      if (id_valid && id_ren[p] && a != 0) begin
        w = -1;
        for (int s = NSTAGE-1; s >= 0; s--)
          if (src_valid[s] && src_wen[s] && src_waddr[s*AW +: AW] == a) w = s;
        if (w >= 0) begin
          if (src_rdy[w]) begin e.hit[p] = 1; e.data[p*XLEN +: XLEN] = src_data[w*XLEN +: XLEN]; end
          else st = 1;
        end else if (lg_done && lg_waddr == a) begin
          e.hit[p] = 1; e.data[p*XLEN +: XLEN] = lg_data;
        end else if (mbusy[a]) st = 1;
      end
    end
    if (id_valid && id_wen && id_long && id_waddr != 0 && mbusy[id_waddr] &&
        !(lg_done && lg_waddr == id_waddr)) st = 1;
    e.stall = st && !flush;
    if (!reset) begin e.hit = '0; e.data = '0; e.stall = 0; end
    e.cnt = mcnt;
  endtask

  task automatic update(input exp_t e);
    if (!reset) begin
      for (int r = 0; r < NREG; r++) mbusy[r] = 0;
      mcnt = 0;
    end else begin
      if (e.stall && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
      if (flush) begin
        for (int r = 0; r < NREG; r++) mbusy[r] = 0;
      end else begin
        if (lg_done) mbusy[lg_waddr] = 0;
        if (issue_fire && id_wen && id_long && id_waddr != 0) mbusy[id_waddr] = 1;
      end
    end
  endtask

  // Called right after inputs are driven at the falling edge
  task automatic step(input bit fire_req);
    exp_t e;
    predict(e);
    exp_q.push_back(e);
    issue_fire = fire_req && !e.stall;
    update(e);
  endtask

  task automatic dchk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: compare each presented output set against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (id_fwd_hit !== e.hit || id_fwd_data !== e.data || id_stall !== e.stall || stall_cnt !== e.cnt) begin
          errors++;
          $display("FAIL sb t=%0t: hit %b/%b stall %b/%b cnt %0d/%0d data %h/%h", $time,
                   id_fwd_hit, e.hit, id_stall, e.stall, stall_cnt, e.cnt, id_fwd_data, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: driver did not complete");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    mcnt = 0;
    for (int r = 0; r < NREG; r++) mbusy[r] = 0;
    clear_inputs();
    reset = 0;
    repeat (2) begin @(negedge clock); step(0); end
    #4; dchk("reset_cnt", 64'(stall_cnt), 64'd0);

    // 1: youngest stage wins
    @(negedge clock); clear_inputs(); reset = 1;
    set_src(0, 5, 1, 64'hAA); set_src(1, 5, 1, 64'hBB); set_rd(0, 5); step(0);
    #4; dchk("t1_hit", 64'(id_fwd_hit[0]), 64'd1); dchk("t1_data", id_fwd_data[63:0], 64'hAA);
    dchk("t1_stall", 64'(id_stall), 64'd0);

    // 2: load-use stall, then forward from MEM
    @(negedge clock); clear_inputs(); set_src(0, 7, 0, 64'h0); set_rd(1, 7); step(0);
    #4; dchk("t2_stall", 64'(id_stall), 64'd1); dchk("t2_hit", 64'(id_fwd_hit[1]), 64'd0);
    @(negedge clock); clear_inputs(); set_src(1, 7, 1, 64'h11); set_rd(1, 7); step(0);
    #4; dchk("t2_stall2", 64'(id_stall), 64'd0); dchk("t2_data", id_fwd_data[127:64], 64'h11);
    dchk("t2_cnt", 64'(stall_cnt), 64'd1);

    // 3: long op owes x9
    @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 9; step(1);
    repeat (6) begin
      @(negedge clock); clear_inputs(); set_rd(0, 9); step(1);
      #4; dchk("t3_stall", 64'(id_stall), 64'd1);
    end
    @(negedge clock); clear_inputs(); set_rd(0, 9); lg_done = 1; lg_waddr = 9; lg_data = 64'h42; step(0);
    #4; dchk("t3_done_stall", 64'(id_stall), 64'd0); dchk("t3_data", id_fwd_data[63:0], 64'h42);
    @(negedge clock); clear_inputs(); set_rd(0, 9); step(0);
    #4; dchk("t3_cleared", 64'(id_stall), 64'd0);

    // 4: WAW on x9, writeback and reissue in the same cycle keeps it owed
    @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 9; step(1);
    repeat (3) begin
      @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 9; step(1);
      #4; dchk("t4_waw", 64'(id_stall), 64'd1);
    end
    @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 9;
    lg_done = 1; lg_waddr = 9; step(1);
    #4; dchk("t4_release", 64'(id_stall), 64'd0);
    @(negedge clock); clear_inputs(); set_rd(1, 9); step(0);
    #4; dchk("t4_still_busy", 64'(id_stall), 64'd1);

    // 5: x0 never forwards; flush clears the scoreboard
    @(negedge clock); clear_inputs(); set_src(0, 0, 1, 64'h77); set_rd(0, 0); step(0);
    #4; dchk("t5_x0_hit", 64'(id_fwd_hit), 64'd0); dchk("t5_x0_stall", 64'(id_stall), 64'd0);
    @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 3; step(1);
    @(negedge clock); clear_inputs(); set_rd(0, 3); flush = 1; step(0);
    #4; dchk("t5_flush_mask", 64'(id_stall), 64'd0);
    @(negedge clock); clear_inputs(); set_rd(0, 3); set_rd(1, 9); step(0);
    #4; dchk("t5_flushed", 64'(id_stall), 64'd0);

    // 6: reset during a stall
    @(negedge clock); clear_inputs(); id_valid = 1; id_wen = 1; id_long = 1; id_waddr = 4; step(1);
    @(negedge clock); clear_inputs(); set_rd(0, 4); set_src(2, 6, 1, 64'h5); set_rd(1, 6); reset = 0; step(0);
    #4; dchk("t6_stall", 64'(id_stall), 64'd0); dchk("t6_hit", 64'(id_fwd_hit), 64'd0);
    dchk("t6_data", id_fwd_data[127:64], 64'd0);
    @(negedge clock); clear_inputs(); reset = 1; step(0);
    #4; dchk("t6_cnt", 64'(stall_cnt), 64'd0);

    // Random traffic over a small register window so hazards are frequent
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      clear_inputs();
      reset = ($urandom_range(0, 199) != 0);
      for (int s = 0; s < NSTAGE; s++) begin
        src_valid[s] = $urandom_range(0, 1);
        src_wen[s]   = $urandom_range(0, 3) != 0;
        src_waddr[s*AW +: AW] = AW'($urandom_range(0, 7));
        src_rdy[s]   = $urandom_range(0, 3) != 0;
        src_data[s*XLEN +: XLEN] = {$urandom, $urandom};
      end
      id_valid = $urandom_range(0, 7) != 0;
      id_ren   = NRP'($urandom_range(0, 3));
      for (int p = 0; p < NRP; p++) id_raddr[p*AW +: AW] = AW'($urandom_range(0, 7));
      id_wen   = $urandom_range(0, 1);
      id_long  = $urandom_range(0, 2) == 0;
      id_waddr = AW'($urandom_range(0, 7));
      lg_done  = $urandom_range(0, 3) == 0;
      lg_waddr = AW'($urandom_range(0, 7));
      lg_data  = {$urandom, $urandom};
      flush    = $urandom_range(0, 29) == 0;
      step($urandom_range(0, 1));
    end

    @(negedge clock); clear_inputs(); reset = 1;
    repeat (3) @(negedge clock);
    dchk("queue_drained", 64'(exp_q.size()), 64'd0);
    drv_done = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
